// File: rtl/pattern_serial_tx_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state encoding
// and the default 1011 pattern expected by the loopback detector.
package pattern_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEF_PATTERN_1011 = 4'b1011;

endpackage

// File: rtl/pattern_serial_tx_if.sv
// Control and serial-line bundle of the pattern transmitter.
// The master drives the control inputs; the slave is the transmitter.
interface pattern_serial_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
);

  logic             start;
  logic             use_default;
  logic [WIDTH-1:0] pattern_in;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, use_default, pattern_in, repeat_cnt, gap_len, abort,
    input  serial_out, serial_valid, frame_start, busy, done
  );

  modport slave (
    input  start, use_default, pattern_in, repeat_cnt, gap_len, abort,
    output serial_out, serial_valid, frame_start, busy, done
  );

endinterface

// File: rtl/pattern_serial_tx_piso_shift_reg.sv
// Parallel-load, MSB-first shift register. Zeros shift in from the LSB, so the
// register drains to all-zero after WIDTH shifts.
module pattern_serial_tx_piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: sends repeat_cnt+1 frames of a WIDTH-bit pattern,
// MSB first, with gap_len idle cycles between frames. All outputs registered.
module pattern_serial_tx
  import pattern_serial_tx_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(DEF_PATTERN_1011),
  parameter int               CNT_W       = 4,
  parameter int               GAP_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  pattern_serial_tx_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [WIDTH-1:0] r_pat;
  logic             r_valid;
  logic             r_frame_start;
  logic             r_busy;
  logic             r_done;

  logic             w_abort_ok;
  logic             w_start_ok;
  logic             w_frame_end;
  logic             w_more_frames;
  logic             w_next_frame;
  logic             w_load;
  logic             w_shift;
  logic             w_clear;
  logic [WIDTH-1:0] w_load_val;
  logic             w_piso_msb;

  // Abort only matters outside IDLE; in IDLE it still suppresses a start.
  assign w_abort_ok    = bus.abort && (r_state != ST_IDLE);
  assign w_start_ok    = bus.start && !bus.abort && (r_state == ST_IDLE);
  assign w_frame_end   = (r_state == ST_SHIFT) && (r_bit_idx == '0);
  assign w_more_frames = (r_frame_cnt != '0);
  assign w_next_frame  = (w_frame_end && w_more_frames && (r_gap_len == '0)) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == GAP_W'(1)));

  assign w_load_val = (r_state == ST_IDLE) ?
                      (bus.use_default ? DEF_PATTERN : bus.pattern_in) : r_pat;

  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_clear = 1'b0;
    if (w_abort_ok) begin
      w_clear = 1'b1;
    end else if (w_start_ok || w_next_frame) begin
      w_load = 1'b1;
    end else if (r_state == ST_SHIFT) begin
      w_shift = 1'b1;
    end
  end

  // The shift register's MSB is the line itself; it is zero whenever no bit is sent.
  pattern_serial_tx_piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_load_val),
    .o_msb   (w_piso_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit_idx     <= '0;
      r_frame_cnt   <= '0;
      r_gap_len     <= '0;
      r_gap_cnt     <= '0;
      r_pat         <= '0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (w_abort_ok) begin
      r_state       <= ST_IDLE;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_start_ok) begin
            r_pat         <= w_load_val;
            r_frame_cnt   <= bus.repeat_cnt;
            r_gap_len     <= bus.gap_len;
            r_bit_idx     <= LAST_IDX;
            r_valid       <= 1'b1;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_frame_start <= 1'b0;
          if (r_bit_idx != '0) begin
            r_bit_idx <= r_bit_idx - IDX_W'(1);
          end else if (w_more_frames) begin
            r_frame_cnt <= r_frame_cnt - CNT_W'(1);
            if (r_gap_len != '0) begin
              r_gap_cnt <= r_gap_len;
              r_valid   <= 1'b0;
              r_state   <= ST_GAP;
            end else begin
              r_bit_idx     <= LAST_IDX;
              r_frame_start <= 1'b1;
            end
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(1)) begin
            r_bit_idx     <= LAST_IDX;
            r_valid       <= 1'b1;
            r_frame_start <= 1'b1;
            r_state       <= ST_SHIFT;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.serial_out   = w_piso_msb;
  assign bus.serial_valid = r_valid;
  assign bus.frame_start  = r_frame_start;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Table-driven and randomized check of pattern_serial_tx against a frame-level
// model that lists the expected output of every cycle of a transmission.
module tb_pattern_serial_tx;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int GW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_serial_tx_if #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) bus ();

  pattern_serial_tx #(
    .WIDTH       (W),
    .DEF_PATTERN (4'b1011),
    .CNT_W       (CW),
    .GAP_W       (GW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [3:0] pat;
    logic       use_def;
    int         rep;
    int         gap;
    int         abort_cyc;
    bit         by_reset;
    int         bs_cyc;
    int         ncyc;
    int         exp_done;
    int         exp_det;
  } vec_t;

  vec_t tbl[12];

  // {serial_out, serial_valid, frame_start, busy, done}
  function automatic logic [4:0] outs();
    return {bus.serial_out, bus.serial_valid, bus.frame_start, bus.busy, bus.done};
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_txn(input string name, input logic [3:0] pat, input logic use_def,
                         input int rep, input int gap, input int ab, input bit by_rst,
                         input int bs, input int ncyc, output int done_cyc, output int det);
    logic [4:0] exp_q[$];
    logic [3:0] p;
    logic [4:0] e;
    logic [4:0] a;
    logic [3:0] hist;
    int         nvalid;
    p = use_def ? 4'b1011 : pat;
    for (int f = 0; f <= rep; f++) begin
      for (int i = W - 1; i >= 0; i--)
        exp_q.push_back({p[i], 1'b1, (i == W - 1), 1'b1, 1'b0});
      if (f < rep)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00001);

    @(negedge clk);
    bus.start       = 1'b1;
    bus.use_default = use_def;
    bus.pattern_in  = pat;
    bus.repeat_cnt  = 4'(rep);
    bus.gap_len     = 3'(gap);
    bus.abort       = 1'b0;
    done_cyc = 0;
    det      = 0;
    hist     = '0;
    nvalid   = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      e = (n <= exp_q.size()) ? exp_q[n-1] : 5'b0;
      if (ab > 0 && n > ab) e = 5'b0;
      a = outs();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s cyc%0d: out/val/fs/busy/done got %b want %b", name, n, a, e);
      end
      if (a[0] && done_cyc == 0) done_cyc = n;
      if (a[3]) begin
        hist = {hist[2:0], a[4]};
        nvalid++;
        if (nvalid >= 4 && hist == 4'b1011) det++;
      end
      bus.start       = (n == bs);
      bus.abort       = (!by_rst && n == ab);
      reset           = (by_rst && n == ab);
      bus.pattern_in  = 4'($urandom);
      bus.use_default = 1'($urandom);
      bus.repeat_cnt  = 4'($urandom);
      bus.gap_len     = 3'($urandom);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
    $display("txn %s: pat=%b def=%0d rep=%0d gap=%0d abort@%0d done@%0d det=%0d",
             name, pat, use_def, rep, gap, ab, done_cyc, det);
  endtask

  initial begin
    int dc;
    int dt;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.use_default = 1'b0;
    bus.pattern_in  = '0;
    bus.repeat_cnt  = '0;
    bus.gap_len     = '0;
    bus.abort       = 1'b0;

    //                name            pat      def  rep gap ab rst bs  ncyc done det
    tbl[0]  = '{"default_single", 4'b0000, 1'b1, 0,  0,  0, 0,  0,  6,   5,   1};
    tbl[1]  = '{"repeat_gap",     4'b1100, 1'b0, 2,  2,  0, 0,  0,  18,  17, -1};
    tbl[2]  = '{"loopback_b2b",   4'b0000, 1'b1, 3,  0,  0, 0,  0,  18,  17,  4};
    tbl[3]  = '{"start_busy",     4'b0110, 1'b1, 0,  0,  0, 0,  2,  6,   5,   1};
    tbl[4]  = '{"abort_mid",      4'b0000, 1'b1, 0,  0,  3, 0,  0,  5,   0,  -1};
    tbl[5]  = '{"after_abort",    4'b0000, 1'b1, 0,  0,  0, 0,  0,  6,   5,   1};
    tbl[6]  = '{"reset_gap",      4'b1001, 1'b0, 1,  3,  5, 1,  0,  12,  0,  -1};
    tbl[7]  = '{"start_in_done",  4'b0101, 1'b1, 0,  0,  0, 0,  5,  6,   5,   1};
    tbl[8]  = '{"max_repeat",     4'b1011, 1'b0, 15, 0,  0, 0,  0,  66,  65, 16};
    tbl[9]  = '{"max_gap",        4'b0111, 1'b0, 1,  7,  0, 0,  0,  17,  16, -1};
    tbl[10] = '{"zero_pat",       4'b0000, 1'b0, 1,  1,  0, 0,  0,  11,  10,  0};
    tbl[11] = '{"ones_pat",       4'b1111, 1'b0, 0,  5,  0, 0,  0,  6,   5,   0};

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 00000", outs());
    end
    $display("txn reset: outputs=%b", outs());
    reset = 1'b0;

    // Abort and start together in IDLE: start is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== 5'b0) begin
      n_bad++;
      $display("FAIL idle_abort_start: got %b want 00000", outs());
    end
    $display("txn idle_abort_start: outputs=%b", outs());
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== 5'b0) begin
      n_bad++;
      $display("FAIL idle_abort: got %b want 00000", outs());
    end
    $display("txn idle_abort: outputs=%b", outs());
    bus.abort = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].name, tbl[i].pat, tbl[i].use_def, tbl[i].rep, tbl[i].gap,
              tbl[i].abort_cyc, tbl[i].by_reset, tbl[i].bs_cyc, tbl[i].ncyc, dc, dt);
      check_int({tbl[i].name, "_done_cycle"}, dc, tbl[i].exp_done);
      if (tbl[i].exp_det >= 0) check_int({tbl[i].name, "_detects"}, dt, tbl[i].exp_det);
    end

    for (int r = 0; r < 20; r++) begin
      logic [3:0] rp;
      logic       rd;
      int         rrep;
      int         rgap;
      int         len;
      int         rab;
      rp   = 4'($urandom);
      rd   = 1'($urandom);
      rrep = int'($urandom_range(0, 3));
      rgap = int'($urandom_range(0, 7));
      len  = (rrep + 1) * W + rrep * rgap + 1;
      rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      run_txn($sformatf("rand%0d", r), rp, rd, rrep, rgap, rab, 1'($urandom_range(0, 1)),
              0, len + 1, dc, dt);
      check_int($sformatf("rand%0d_done_cycle", r), dc, (rab > 0) ? 0 : len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
